// File: rtl/rfsoc_config.sv
// rfsoc_config: shared GPIO bit map and command-target encoding for the rfsoc_pl_ctrl configuration bus.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package rfsoc_config;

    // Bit positions on the 16-bit gpio_ctrl bus as wired into rfsoc_pl_ctrl.
    localparam int sdata                 = 0;
    localparam int trigger_line          = 1;
    localparam int channel_sel_clk       = 2;
    localparam int cycle_count_clk       = 3;
    localparam int mask_clk              = 4;
    localparam int locking_waveform_clk  = 5;
    localparam int pre_delay_cycle_clk   = 6;
    localparam int post_delay_cycle_clk  = 7;
    localparam int mux_set_clk           = 8;
    localparam int mask_enable_clk       = 9;

    localparam int GPIO_W     = 16;
    localparam int DATA_W     = 256;
    localparam int NBITS_W    = 9;
    localparam int PHASE_W    = 4;

    // Configuration register selected by a command; encodings 8..15 are invalid.
    typedef enum logic [3:0] {
        CHAN_SEL    = 4'd0,
        CYCLE_COUNT = 4'd1,
        MASK        = 4'd2,
        LOCK_WAVE   = 4'd3,
        PRE_DELAY   = 4'd4,
        POST_DELAY  = 4'd5,
        MUX_SET     = 4'd6,
        MASK_EN     = 4'd7
    } cfg_target_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SETUP,
        TX_HIGH,
        TX_HOLD,
        TX_FIN,
        TX_TRIG
    } tx_state_t;

    function automatic logic is_cfg_target(input logic [3:0] raw);
        logic ok;
        ok = 1'b0;
        case (raw)
            CHAN_SEL, CYCLE_COUNT, MASK, LOCK_WAVE,
            PRE_DELAY, POST_DELAY, MUX_SET, MASK_EN: ok = 1'b1;
            default:                                 ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Strobe line that clocks the selected register inside rfsoc_pl_ctrl.
    function automatic logic [3:0] target_to_gpio_bit(input cfg_target_t t);
        logic [3:0] b;
        case (t)
            CHAN_SEL:    b = 4'(channel_sel_clk);
            CYCLE_COUNT: b = 4'(cycle_count_clk);
            MASK:        b = 4'(mask_clk);
            LOCK_WAVE:   b = 4'(locking_waveform_clk);
            PRE_DELAY:   b = 4'(pre_delay_cycle_clk);
            POST_DELAY:  b = 4'(post_delay_cycle_clk);
            MUX_SET:     b = 4'(mux_set_clk);
            MASK_EN:     b = 4'(mask_enable_clk);
            default:     b = 4'(channel_sel_clk);
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rfsoc_gpio_cfg_tx.sv
// rfsoc_gpio_cfg_tx: serializes one config command onto the rfsoc_pl_ctrl sdata/strobe GPIO bus (LSB first) and issues trigger pulses.
// Latency: first sdata the cycle after acceptance; done N*(SETUP_CYC+HIGH_CYC+HOLD_CYC)+1 cycles after accepting an N-bit command.
// Backpressure: cmd_ready only in IDLE with no trig_req present; one command in flight, trig_req outside IDLE is dropped.
//
// Ports:
//   ps_clk, rst              clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake; cmd_target/cmd_data/cmd_nbits sampled on acceptance
//   trig_req                 request a TRIG_CYC-long pulse on trigger_line (wins over a same-cycle command)
//   gpio_ctrl                registered GPIO bus into rfsoc_pl_ctrl; unused bits held 0
//   busy, done, err          status: not-idle, one-cycle completion pulse, rejection qualifier for done
module rfsoc_gpio_cfg_tx
    import rfsoc_config::*;
#(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned HIGH_CYC  = 2,
    parameter int unsigned HOLD_CYC  = 2,
    parameter int unsigned TRIG_CYC  = 1
) (
    input  logic                 ps_clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_target,
    input  logic [DATA_W-1:0]    cmd_data,
    input  logic [NBITS_W-1:0]   cmd_nbits,
    input  logic                 trig_req,
    output logic [GPIO_W-1:0]    gpio_ctrl,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    tx_state_t             state,      state_nxt;
    logic [PHASE_W-1:0]    ph_cnt,     ph_nxt;
    logic [DATA_W-1:0]     shreg,      sh_nxt;
    logic [NBITS_W-1:0]    bit_cnt,    bc_nxt;
    logic [3:0]            strobe_bit, sb_nxt;
    logic                  err_nxt;
    logic [GPIO_W-1:0]     gpio_q,     gpio_nxt;
    logic                  ready_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    // Phase counters are loaded with (length-1) and the phase ends when they read 0.
    localparam logic [PHASE_W-1:0] SETUP_LD = PHASE_W'(SETUP_CYC - 1);
    localparam logic [PHASE_W-1:0] HIGH_LD  = PHASE_W'(HIGH_CYC - 1);
    localparam logic [PHASE_W-1:0] HOLD_LD  = PHASE_W'(HOLD_CYC - 1);
    localparam logic [PHASE_W-1:0] TRIG_LD  = PHASE_W'(TRIG_CYC - 1);

    always_comb begin
        state_nxt = state;
        ph_nxt    = ph_cnt;
        sh_nxt    = shreg;
        bc_nxt    = bit_cnt;
        sb_nxt    = strobe_bit;
        err_nxt   = 1'b0;
        gpio_nxt  = '0;

        unique case (state)
            TX_IDLE: begin
                if (trig_req) begin
                    state_nxt = TX_TRIG;
                    ph_nxt    = TRIG_LD;
                end else if (cmd_valid) begin
                    if (cmd_nbits > 9'd256 || !is_cfg_target(cmd_target)) begin
                        state_nxt = TX_FIN;
                        err_nxt   = 1'b1;
                    end else if (cmd_nbits == '0) begin
                        state_nxt = TX_FIN;
                    end else begin
                        state_nxt = TX_SETUP;
                        ph_nxt    = SETUP_LD;
                        sh_nxt    = cmd_data;
                        bc_nxt    = cmd_nbits;
                        sb_nxt    = target_to_gpio_bit(cfg_target_t'(cmd_target));
                    end
                end
            end
            TX_SETUP: begin
                if (ph_cnt == '0) begin
                    state_nxt = TX_HIGH;
                    ph_nxt    = HIGH_LD;
                end else begin
                    ph_nxt    = ph_cnt - 1'b1;
                end
            end
            TX_HIGH: begin
                if (ph_cnt == '0) begin
                    state_nxt = TX_HOLD;
                    ph_nxt    = HOLD_LD;
                end else begin
                    ph_nxt    = ph_cnt - 1'b1;
                end
            end
            TX_HOLD: begin
                if (ph_cnt == '0) begin
                    // Shift only here, while the strobe is low, so sdata never moves under a high strobe.
                    sh_nxt = {1'b0, shreg[DATA_W-1:1]};
                    bc_nxt = bit_cnt - 1'b1;
                    if (bit_cnt == 9'd1) begin
                        state_nxt = TX_FIN;
                    end else begin
                        state_nxt = TX_SETUP;
                        ph_nxt    = SETUP_LD;
                    end
                end else begin
                    ph_nxt = ph_cnt - 1'b1;
                end
            end
            TX_FIN: begin
                state_nxt = TX_IDLE;
            end
            TX_TRIG: begin
                if (ph_cnt == '0) begin
                    state_nxt = TX_IDLE;
                end else begin
                    ph_nxt    = ph_cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = TX_IDLE;
            end
        endcase

        // GPIO image is decoded from the next state so the bus itself comes straight from flops.
        case (state_nxt)
            TX_SETUP, TX_HOLD: begin
                gpio_nxt[sdata] = sh_nxt[0];
            end
            TX_HIGH: begin
                gpio_nxt[sdata]  = sh_nxt[0];
                gpio_nxt[sb_nxt] = 1'b1;
            end
            TX_TRIG: begin
                gpio_nxt[trigger_line] = 1'b1;
            end
            default: begin
                gpio_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge ps_clk or posedge rst) begin
        if (rst) begin
            state      <= TX_IDLE;
            ph_cnt     <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            strobe_bit <= '0;
            gpio_q     <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            ph_cnt     <= ph_nxt;
            shreg      <= sh_nxt;
            bit_cnt    <= bc_nxt;
            strobe_bit <= sb_nxt;
            gpio_q     <= gpio_nxt;
            ready_q    <= (state_nxt == TX_IDLE);
            busy_q     <= (state_nxt != TX_IDLE);
            done_q     <= (state_nxt == TX_FIN);
            err_q      <= err_nxt;
        end
    end

    // A trigger request in IDLE takes the slot, so the command must see ready low that cycle.
    assign cmd_ready = ready_q & ~trig_req;
    assign gpio_ctrl = gpio_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rfsoc_gpio_cfg_tx.sv
// tb_rfsoc_gpio_cfg_tx: scoreboard bench for the GPIO config serializer.
// Latency: n/a.
// Backpressure: n/a.
module tb_rfsoc_gpio_cfg_tx;
    import rfsoc_config::*;

    typedef struct packed {
        logic [3:0] strobe;
        logic       sdata;
    } pulse_t;

    localparam logic [15:0] STROBES = 16'((1 << channel_sel_clk) | (1 << cycle_count_clk) |
                                          (1 << mask_clk) | (1 << locking_waveform_clk) |
                                          (1 << pre_delay_cycle_clk) | (1 << post_delay_cycle_clk) |
                                          (1 << mux_set_clk) | (1 << mask_enable_clk));
    localparam logic [15:0] OWNED   = STROBES | 16'(1 << sdata) | 16'(1 << trigger_line);

    logic         ps_clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [3:0]   cmd_target = '0;
    logic [255:0] cmd_data = '0;
    logic [8:0]   cmd_nbits = '0;
    logic         trig_req = 1'b0;
    logic [15:0]  gpio_ctrl;
    logic         busy;
    logic         done;
    logic         err;

    int tests = 0;
    int fails = 0;

    // Monitor-owned observation state.
    pulse_t      exp_q[$];
    pulse_t      obs_q[$];
    logic [15:0] prev_gpio = '0;
    int          strobe_pulses = 0;
    int          sdata_hi_pulses = 0;
    int          trig_cycles = 0;
    int          inv_viol = 0;

    rfsoc_gpio_cfg_tx dut (
        .ps_clk     (ps_clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_data   (cmd_data),
        .cmd_nbits  (cmd_nbits),
        .trig_req   (trig_req),
        .gpio_ctrl  (gpio_ctrl),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 ps_clk = ~ps_clk;

    function automatic logic [3:0] tb_bit(input logic [3:0] t);
        case (t)
            4'd0:    return 4'(channel_sel_clk);
            4'd1:    return 4'(cycle_count_clk);
            4'd2:    return 4'(mask_clk);
            4'd3:    return 4'(locking_waveform_clk);
            4'd4:    return 4'(pre_delay_cycle_clk);
            4'd5:    return 4'(post_delay_cycle_clk);
            4'd6:    return 4'(mux_set_clk);
            4'd7:    return 4'(mask_enable_clk);
            default: return 4'd0;
        endcase
    endfunction

    // Records every strobe rising edge and flags protocol invariants on the bus.
    always @(negedge ps_clk) begin : mon
        logic [15:0] cur;
        logic [15:0] rise;
        pulse_t      o;
        if (rst) begin
            prev_gpio = '0;
        end else begin
            cur  = gpio_ctrl;
            rise = cur & ~prev_gpio & STROBES;
            if (cur[trigger_line]) trig_cycles++;
            if ((cur & ~OWNED) != 16'd0) begin
                inv_viol++;
                $display("invariant broken: unused gpio bits %h at %0t", cur, $time);
            end
            if ($countones(cur & STROBES) > 1) begin
                inv_viol++;
                $display("invariant broken: several strobes high %h at %0t", cur, $time);
            end
            if ((((prev_gpio & STROBES) != 16'd0) || (rise != 16'd0)) && (cur[sdata] != prev_gpio[sdata])) begin
                inv_viol++;
                $display("invariant broken: sdata moved around a strobe at %0t", $time);
            end
            if (rise != 16'd0) begin
                o.strobe = 4'd0;
                for (int i = 0; i < 16; i++) if (rise[i]) o.strobe = 4'(i);
                o.sdata = cur[sdata];
                obs_q.push_back(o);
                strobe_pulses++;
                if (cur[sdata]) sdata_hi_pulses++;
            end
            prev_gpio = cur;
        end
    end

    // Driver only: presents a command, waits (bounded) for acceptance and queues the expected pulses.
    task automatic send_cmd(input logic [3:0] tgt, input logic [255:0] dat, input logic [8:0] nb,
                            output bit accepted);
        int     guard;
        pulse_t e;
        guard = 0;
        @(negedge ps_clk);
        cmd_target = tgt;
        cmd_data   = dat;
        cmd_nbits  = nb;
        cmd_valid  = 1'b1;
        #1;
        while (!cmd_ready && guard < 100) begin
            @(negedge ps_clk);
            #1;
            guard++;
        end
        accepted = cmd_ready;
        @(posedge ps_clk);
        #1;
        cmd_valid = 1'b0;
        if (accepted && tgt < 4'd8 && nb <= 9'd256) begin
            for (int i = 0; i < int'(nb); i++) begin
                e.strobe = tb_bit(tgt);
                e.sdata  = dat[i];
                exp_q.push_back(e);
            end
        end
    endtask

    // Counts cycles from just after an accept edge to the cycle showing done; -1 if the budget runs out.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge ps_clk);
            n++;
        end while (!done && n < 5000);
        if (!done) n = -1;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge ps_clk);
        tests++; if (gpio_ctrl !== 16'h0) begin fails++; $display("FAIL reset_gpio: got %h want 0000", gpio_ctrl); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_in_rst: got %b want 0", cmd_ready); end
        tests++; if (done !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL reset_done_err: got %b%b want 00", done, err); end
        rst = 1'b0;
        @(negedge ps_clk);
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_after: got %b want 1", cmd_ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_chan_sel;
        bit     acc;
        int     n;
        int     hi0;
        int     p0;
        pulse_t e;
        pulse_t o;
        hi0 = sdata_hi_pulses;
        p0  = strobe_pulses;
        send_cmd(CHAN_SEL, 256'h0020, 9'd16, acc);
        tests++; if (!acc) begin fails++; $display("FAIL chan_sel_accept: got 0 want 1"); end
        wait_done(n);
        tests++; if (n != 97) begin fails++; $display("FAIL chan_sel_done_cycle: got %0d want 97", n); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL chan_sel_err: got %b want 0", err); end
        tests++; if (gpio_ctrl !== 16'h0) begin fails++; $display("FAIL chan_sel_fin_gpio: got %h want 0000", gpio_ctrl); end
        tests++; if (strobe_pulses - p0 != 16) begin fails++; $display("FAIL chan_sel_pulses: got %0d want 16", strobe_pulses - p0); end
        tests++; if (sdata_hi_pulses - hi0 != 1) begin fails++; $display("FAIL chan_sel_sdata_hi: got %0d want 1", sdata_hi_pulses - hi0); end
        while (exp_q.size() > 0) begin
            tests++;
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                fails++; $display("FAIL chan_sel_pulse: got none want strobe %0d sdata %0b", e.strobe, e.sdata);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL chan_sel_pulse: got strobe %0d sdata %0b want strobe %0d sdata %0b", o.strobe, o.sdata, e.strobe, e.sdata); end
            end
        end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL chan_sel_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_cycle_count;
        bit           acc;
        int           n;
        int           idx;
        logic [255:0] rx;
        pulse_t       e;
        pulse_t       o;
        rx  = '0;
        idx = 0;
        send_cmd(CYCLE_COUNT, 256'd10, 9'd256, acc);
        tests++; if (!acc) begin fails++; $display("FAIL cycle_count_accept: got 0 want 1"); end
        wait_done(n);
        tests++; if (n != 1537) begin fails++; $display("FAIL cycle_count_done_cycle: got %0d want 1537", n); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL cycle_count_err: got %b want 0", err); end
        while (exp_q.size() > 0) begin
            tests++;
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                fails++; $display("FAIL cycle_count_pulse: got none want strobe %0d sdata %0b", e.strobe, e.sdata);
            end else begin
                o = obs_q.pop_front();
                if (idx < 256 && o.strobe == 4'(cycle_count_clk)) rx[idx] = o.sdata;
                idx++;
                if (o !== e) begin fails++; $display("FAIL cycle_count_pulse: got strobe %0d sdata %0b want strobe %0d sdata %0b", o.strobe, o.sdata, e.strobe, e.sdata); end
            end
        end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL cycle_count_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
        tests++; if (rx !== 256'd10) begin fails++; $display("FAIL cycle_count_loopback: got %0d want 10", rx); end
    endtask

    task automatic test_mask_en_trig_ignored;
        bit     acc;
        int     n;
        int     hi0;
        int     t0;
        pulse_t e;
        pulse_t o;
        hi0 = sdata_hi_pulses;
        t0  = trig_cycles;
        send_cmd(MASK_EN, 256'hFF, 9'd8, acc);
        tests++; if (!acc) begin fails++; $display("FAIL mask_en_accept: got 0 want 1"); end
        @(negedge ps_clk);
        trig_req = 1'b1;
        @(negedge ps_clk);
        trig_req = 1'b0;
        @(negedge ps_clk);
        wait_done(n);
        if (n > 0) n = n + 3;
        tests++; if (n != 49) begin fails++; $display("FAIL mask_en_done_cycle: got %0d want 49", n); end
        tests++; if (sdata_hi_pulses - hi0 != 8) begin fails++; $display("FAIL mask_en_sdata_hi: got %0d want 8", sdata_hi_pulses - hi0); end
        tests++; if (trig_cycles != t0) begin fails++; $display("FAIL busy_trig_ignored: got %0d trigger cycles want 0", trig_cycles - t0); end
        while (exp_q.size() > 0) begin
            tests++;
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                fails++; $display("FAIL mask_en_pulse: got none want strobe %0d sdata %0b", e.strobe, e.sdata);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL mask_en_pulse: got strobe %0d sdata %0b want strobe %0d sdata %0b", o.strobe, o.sdata, e.strobe, e.sdata); end
            end
        end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL mask_en_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_trig_priority;
        int t0;
        int p0;
        t0 = trig_cycles;
        p0 = strobe_pulses;
        @(negedge ps_clk);
        trig_req   = 1'b1;
        cmd_valid  = 1'b1;
        cmd_target = CHAN_SEL;
        cmd_data   = '1;
        cmd_nbits  = 9'd0;
        #1;
        tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL trig_ready_low: got %b want 0", cmd_ready); end
        @(posedge ps_clk);
        #1;
        trig_req = 1'b0;
        @(negedge ps_clk);
        tests++; if (gpio_ctrl !== 16'(1 << trigger_line)) begin fails++; $display("FAIL trig_pulse: got %h want %h", gpio_ctrl, 16'(1 << trigger_line)); end
        tests++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin fails++; $display("FAIL trig_busy_ready: got %b%b want 10", busy, cmd_ready); end
        @(negedge ps_clk);
        tests++; if (gpio_ctrl[trigger_line] !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL trig_end: got trig %b ready %b want 0 1", gpio_ctrl[trigger_line], cmd_ready); end
        @(posedge ps_clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge ps_clk);
        tests++; if (done !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL nbits0_done: got done %b err %b want 1 0", done, err); end
        tests++; if (gpio_ctrl !== 16'h0) begin fails++; $display("FAIL nbits0_gpio: got %h want 0000", gpio_ctrl); end
        @(negedge ps_clk);
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL nbits0_done_pulse: got %b want 0", done); end
        tests++; if (trig_cycles - t0 != 1) begin fails++; $display("FAIL trig_cycles: got %0d want 1", trig_cycles - t0); end
        tests++; if (strobe_pulses != p0) begin fails++; $display("FAIL nbits0_pulses: got %0d want 0", strobe_pulses - p0); end
    endtask

    task automatic test_back_to_back;
        bit     acc;
        int     n;
        pulse_t e;
        pulse_t o;
        send_cmd(MUX_SET, 256'hA5, 9'd8, acc);
        tests++; if (!acc) begin fails++; $display("FAIL b2b_accept_a: got 0 want 1"); end
        wait_done(n);
        tests++; if (n != 49) begin fails++; $display("FAIL b2b_done_a: got %0d want 49", n); end
        tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_fin: got %b want 0", cmd_ready); end
        cmd_target = MASK_EN;
        cmd_data   = 256'h3C;
        cmd_nbits  = 9'd8;
        cmd_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e.strobe = tb_bit(MASK_EN);
            e.sdata  = cmd_data[i];
            exp_q.push_back(e);
        end
        @(negedge ps_clk);
        tests++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL b2b_idle_gap: got ready %b busy %b want 1 0", cmd_ready, busy); end
        @(posedge ps_clk);
        #1;
        cmd_valid = 1'b0;
        wait_done(n);
        tests++; if (n != 49) begin fails++; $display("FAIL b2b_done_b: got %0d want 49", n); end
        while (exp_q.size() > 0) begin
            tests++;
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                fails++; $display("FAIL b2b_pulse: got none want strobe %0d sdata %0b", e.strobe, e.sdata);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL b2b_pulse: got strobe %0d sdata %0b want strobe %0d sdata %0b", o.strobe, o.sdata, e.strobe, e.sdata); end
            end
        end
        tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL b2b_extra: got %0d extra pulses want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_reject;
        bit acc;
        int n;
        int p0;
        p0 = strobe_pulses;
        send_cmd(4'hF, 256'hFF, 9'd8, acc);
        tests++; if (!acc) begin fails++; $display("FAIL bad_target_accept: got 0 want 1"); end
        wait_done(n);
        tests++; if (n != 1 || err !== 1'b1) begin fails++; $display("FAIL bad_target_done: got cycle %0d err %b want 1 1", n, err); end
        tests++; if (gpio_ctrl !== 16'h0) begin fails++; $display("FAIL bad_target_gpio: got %h want 0000", gpio_ctrl); end
        send_cmd(CHAN_SEL, '1, 9'd300, acc);
        wait_done(n);
        tests++; if (n != 1 || err !== 1'b1) begin fails++; $display("FAIL bad_nbits_done: got cycle %0d err %b want 1 1", n, err); end
        @(negedge ps_clk);
        tests++; if (done !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL reject_pulse_width: got %b%b want 00", done, err); end
        tests++; if (strobe_pulses != p0) begin fails++; $display("FAIL reject_activity: got %0d pulses want 0", strobe_pulses - p0); end
    endtask

    task automatic test_reset_mid;
        bit           acc;
        int           guard;
        int           p0;
        int           dones;
        int           busy_gpio;
        logic [255:0] d;
        pulse_t       e;
        pulse_t       o;
        d = {224'd0, $urandom(), 32'hFFFF_0F0F};
        p0 = strobe_pulses;
        send_cmd(MASK, d, 9'd64, acc);
        tests++; if (!acc) begin fails++; $display("FAIL rst_mid_accept: got 0 want 1"); end
        guard = 0;
        while (strobe_pulses - p0 < 41 && guard < 1000) begin
            @(negedge ps_clk);
            guard++;
        end
        tests++; if (strobe_pulses - p0 != 41) begin fails++; $display("FAIL rst_mid_reach_bit40: got %0d pulses want 41", strobe_pulses - p0); end
        #2;
        rst = 1'b1;
        #1;
        tests++; if (gpio_ctrl !== 16'h0 || busy !== 1'b0) begin fails++; $display("FAIL rst_mid_async: got gpio %h busy %b want 0000 0", gpio_ctrl, busy); end
        for (int i = 0; i < 41; i++) begin
            tests++;
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                fails++; $display("FAIL rst_mid_pulse: got none want strobe %0d sdata %0b", e.strobe, e.sdata);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin fails++; $display("FAIL rst_mid_pulse: got strobe %0d sdata %0b want strobe %0d sdata %0b", o.strobe, o.sdata, e.strobe, e.sdata); end
            end
        end
        exp_q.delete();
        obs_q.delete();
        repeat (2) @(posedge ps_clk);
        @(negedge ps_clk);
        rst = 1'b0;
        dones = 0;
        busy_gpio = 0;
        repeat (20) begin
            @(negedge ps_clk);
            if (done) dones++;
            if (gpio_ctrl != 16'h0 || busy) busy_gpio++;
        end
        tests++; if (dones != 0) begin fails++; $display("FAIL rst_mid_no_done: got %0d done cycles want 0", dones); end
        tests++; if (busy_gpio != 0) begin fails++; $display("FAIL rst_mid_quiet: got %0d active cycles want 0", busy_gpio); end
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready: got %b want 1", cmd_ready); end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        test_reset();
        test_chan_sel();
        test_cycle_count();
        test_mask_en_trig_ignored();
        test_trig_priority();
        test_back_to_back();
        test_reject();
        test_reset_mid();
        tests++; if (inv_viol != 0) begin fails++; $display("FAIL bus_invariants: got %0d violations want 0", inv_viol); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
